// File: rtl/stage_mult_pkg.sv
// Shared widths and helpers for the stage_mult_acc complex dot-product stage.
// Width formulas are functions so every instance derives them from its own parameters.
package stage_mult_pkg;

  localparam int SAT_W = 128;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int calcPw(input int inW);
    return 2 * inW + 1;
  endfunction

  function automatic int calcTw(input int inW, input int lanes);
    return calcPw(inW) + clog2(lanes);
  endfunction

  function automatic int calcAw(input int inW, input int lanes);
    return calcTw(inW, lanes) + 8;
  endfunction

  localparam int PW = calcPw(16);
  localparam int TW = calcTw(16, 8);
  localparam int AW = calcAw(16, 8);

  // Lane fields are passed zero-extended to 64 bits and come back sign-extended.
  function automatic logic signed [31:0] laneI(input logic [63:0] lane, input int inW);
    logic signed [63:0] t;
    t = lane << (64 - inW);
    return 32'(t >>> (64 - inW));
  endfunction

  function automatic logic signed [31:0] laneQ(input logic [63:0] lane, input int inW);
    logic signed [63:0] t;
    t = lane << (64 - 2 * inW);
    return 32'(t >>> (64 - inW));
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input  logic signed [SAT_W-1:0] value,
    input  int                      outW,
    output logic                    clipped
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (outW - 1)) - SAT_W'(1);
    lo = ~hi;
    clipped = 1'b0;
    if (value > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (value < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/stage_mult_acc_cmul_pipe.sv
// One lane's complex multiplier: registered inputs, then registered products (latency 2).
// conj selects X*conj(Y); both stages hold while i_enable is low.
module cmul_pipe
  import stage_mult_pkg::*;
#(
  parameter int IN_W = 16,
  localparam int PW_L = calcPw(IN_W)
) (
  input  logic                   clock,
  input  logic                   i_enable,
  input  logic                   i_conj,
  input  logic [2*IN_W-1:0]      i_x,
  input  logic [2*IN_W-1:0]      i_y,
  output logic signed [PW_L-1:0] o_prodI,
  output logic signed [PW_L-1:0] o_prodQ
);

  logic signed [IN_W-1:0]   r_xr, r_xi, r_yr, r_yi;
  logic                     r_conj;
  logic signed [2*IN_W-1:0] w_rr, w_ii, w_iy, w_ry;
  logic signed [PW_L-1:0]   w_rrE, w_iiE, w_iyE, w_ryE;
  logic signed [PW_L-1:0]   r_prodI, r_prodQ;

  always_ff @(posedge clock) begin
    if (i_enable) begin
      r_xr   <= IN_W'(laneI(64'(i_x), IN_W));
      r_xi   <= IN_W'(laneQ(64'(i_x), IN_W));
      r_yr   <= IN_W'(laneI(64'(i_y), IN_W));
      r_yi   <= IN_W'(laneQ(64'(i_y), IN_W));
      r_conj <= i_conj;
    end
  end

  always_comb begin
    w_rr  = (2*IN_W)'(r_xr) * (2*IN_W)'(r_yr);
    w_ii  = (2*IN_W)'(r_xi) * (2*IN_W)'(r_yi);
    w_iy  = (2*IN_W)'(r_xi) * (2*IN_W)'(r_yr);
    w_ry  = (2*IN_W)'(r_xr) * (2*IN_W)'(r_yi);
    w_rrE = PW_L'(w_rr);
    w_iiE = PW_L'(w_ii);
    w_iyE = PW_L'(w_iy);
    w_ryE = PW_L'(w_ry);
  end

  // Conjugating Y flips the sign of yi, which only swaps the add/subtract pairs.
  always_ff @(posedge clock) begin
    if (i_enable) begin
      r_prodI <= r_conj ? (w_rrE + w_iiE) : (w_rrE - w_iiE);
      r_prodQ <= r_conj ? (w_iyE - w_ryE) : (w_iyE + w_ryE);
    end
  end

  assign o_prodI = r_prodI;
  assign o_prodQ = r_prodQ;

endmodule

// File: rtl/stage_mult_acc.sv
// LANES-wide complex dot product with registered adder tree, block accumulator,
// shift and saturation; every stage is frozen while enable is low.
module stage_mult_acc
  import stage_mult_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    input_strobe,
  input  logic [LANES*2*IN_W-1:0] x_flat,
  input  logic [LANES*2*IN_W-1:0] y_flat,
  input  logic                    conj_y,
  input  logic [7:0]              acc_len,
  input  logic                    clear,
  output logic [2*OUT_W-1:0]      sum,
  output logic                    output_strobe,
  output logic                    overflow
);

  localparam int LOG2L = clog2(LANES);
  localparam int PW_T  = calcPw(IN_W);
  localparam int TW_T  = calcTw(IN_W, LANES);
  localparam int AW_T  = calcAw(IN_W, LANES);
  localparam int NODES = LANES - 1;
  localparam int VD    = LOG2L + 2;

  logic [VD-1:0]           r_vPipe;
  logic signed [PW_T-1:0]  w_prodI [LANES];
  logic signed [PW_T-1:0]  w_prodQ [LANES];
  logic signed [TW_T-1:0]  r_nodeI [NODES];
  logic signed [TW_T-1:0]  r_nodeQ [NODES];
  logic signed [TW_T-1:0]  w_treeI [2*LANES-1];
  logic signed [TW_T-1:0]  w_treeQ [2*LANES-1];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cmul_pipe #(.IN_W(IN_W)) u_cmul (
      .clock    (clock),
      .i_enable (enable),
      .i_conj   (conj_y),
      .i_x      (x_flat[k*2*IN_W +: 2*IN_W]),
      .i_y      (y_flat[k*2*IN_W +: 2*IN_W]),
      .o_prodI  (w_prodI[k]),
      .o_prodQ  (w_prodQ[k])
    );
  end

  // Heap-ordered tree: node n sums children 2n+1 and 2n+2, leaves are the lane products.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      w_treeI[i] = r_nodeI[i];
      w_treeQ[i] = r_nodeQ[i];
    end
    for (int j = 0; j < LANES; j++) begin
      w_treeI[NODES + j] = TW_T'(w_prodI[j]);
      w_treeQ[NODES + j] = TW_T'(w_prodQ[j]);
    end
  end

  always_ff @(posedge clock) begin
    if (enable) begin
      for (int n = 0; n < NODES; n++) begin
        r_nodeI[n] <= w_treeI[2*n+1] + w_treeI[2*n+2];
        r_nodeQ[n] <= w_treeQ[2*n+1] + w_treeQ[2*n+2];
      end
    end
  end

  logic                    w_vAcc, w_first, w_done, w_clipI, w_clipQ;
  logic [7:0]              w_lenIn, w_len, w_nextCount;
  logic signed [AW_T-1:0]  w_addI, w_addQ, w_nextI, w_nextQ;
  logic signed [SAT_W-1:0] w_satI, w_satQ;
  logic [7:0]              r_count, r_len;
  logic signed [AW_T-1:0]  r_accI, r_accQ;
  logic [OUT_W-1:0]        r_sumI, r_sumQ;
  logic                    r_strobe, r_overflow;

  // A clear in the same cycle as a valid sample makes that sample open a new block.
  always_comb begin
    w_vAcc      = r_vPipe[VD-1];
    w_first     = clear || (r_count == 8'd0);
    w_lenIn     = (acc_len == 8'd0) ? 8'd1 : acc_len;
    w_len       = w_first ? w_lenIn : r_len;
    w_addI      = AW_T'(w_treeI[0]);
    w_addQ      = AW_T'(w_treeQ[0]);
    w_nextI     = w_first ? w_addI : (r_accI + w_addI);
    w_nextQ     = w_first ? w_addQ : (r_accQ + w_addQ);
    w_nextCount = w_first ? 8'd1 : (r_count + 8'd1);
    w_done      = w_vAcc && (w_nextCount == w_len);
    w_satI      = saturate(SAT_W'(w_nextI >>> SHIFT), OUT_W, w_clipI);
    w_satQ      = saturate(SAT_W'(w_nextQ >>> SHIFT), OUT_W, w_clipQ);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vPipe    <= '0;
      r_count    <= 8'd0;
      r_len      <= 8'd0;
      r_accI     <= '0;
      r_accQ     <= '0;
      r_sumI     <= '0;
      r_sumQ     <= '0;
      r_strobe   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (enable) begin
      r_vPipe  <= {r_vPipe[VD-2:0], input_strobe};
      r_strobe <= 1'b0;
      if (w_vAcc) begin
        if (w_first) r_len <= w_len;
        if (w_done) begin
          r_count  <= 8'd0;
          r_sumI   <= OUT_W'(w_satI);
          r_sumQ   <= OUT_W'(w_satQ);
          r_strobe <= 1'b1;
          if (w_clipI || w_clipQ) r_overflow <= 1'b1;
        end else begin
          r_count <= w_nextCount;
          r_accI  <= w_nextI;
          r_accQ  <= w_nextQ;
        end
      end else if (clear) begin
        r_count <= 8'd0;
      end
    end
  end

  assign sum           = {r_sumI, r_sumQ};
  assign output_strobe = r_strobe;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_stage_mult_acc.sv
// Directed bench for stage_mult_acc (LANES=8, IN_W=16, OUT_W=32, SHIFT=0).
// A negedge monitor logs every output pulse with its cycle number for the tests to inspect.
module tb_stage_mult_acc;

  localparam logic [63:0] SUM_A    = 64'hFFFFFFD8_00000050;
  localparam logic [63:0] SUM_CONJ = 64'h00000058_00000010;
  localparam logic [63:0] SUM_A4   = 64'hFFFFFF60_00000140;
  localparam logic [63:0] SUM_SAT  = 64'h7FFFFFFF_00000000;
  localparam logic [63:0] SUM_B4   = 64'h00000140_00000040;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         input_strobe;
  logic [255:0] x_flat;
  logic [255:0] y_flat;
  logic         conj_y;
  logic [7:0]   acc_len;
  logic         clear;
  logic [63:0]  sum;
  logic         output_strobe;
  logic         overflow;

  typedef struct {
    int          c;
    logic [63:0] s;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  testsRun = 0;
  int  testsFailed = 0;

  stage_mult_acc #(.LANES(8), .IN_W(16), .OUT_W(32), .SHIFT(0)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .input_strobe  (input_strobe),
    .x_flat        (x_flat),
    .y_flat        (y_flat),
    .conj_y        (conj_y),
    .acc_len       (acc_len),
    .clear         (clear),
    .sum           (sum),
    .output_strobe (output_strobe),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    ev_t e;
    if (reset === 1'b1 && output_strobe === 1'b1) begin
      e.c = cyc;
      e.s = sum;
      evq.push_back(e);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_lanes(input logic [15:0] xi, input logic [15:0] xq,
                           input logic [15:0] yi, input logic [15:0] yq);
    for (int k = 0; k < 8; k++) begin
      x_flat[k*32 +: 32] = {xq, xi};
      y_flat[k*32 +: 32] = {yq, yi};
    end
  endtask

  task automatic strobes(input int n);
    input_strobe = 1'b1;
    tick(n);
    input_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    testsRun++;
    if (output_strobe !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_strobe got %b expected 0", output_strobe);
    end
    testsRun++;
    if (sum !== 64'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_sum got %h expected 0", sum);
    end
    testsRun++;
    if (overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_overflow got %b expected 0", overflow);
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    int c0;
    int lat;
    logic [63:0] got;
    evq.delete();
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    conj_y = 1'b0;
    acc_len = 8'd1;
    c0 = cyc;
    strobes(1);
    tick(10);
    lat = (evq.size() > 0) ? evq[0].c - c0 : -1;
    got = (evq.size() > 0) ? evq[0].s : 64'hx;
    testsRun++;
    if (evq.size() !== 1) begin
      testsFailed++;
      $display("[TB] FAIL basic_count got %0d expected 1", evq.size());
    end
    testsRun++;
    if (lat !== 6) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency got %0d expected 6", lat);
    end
    testsRun++;
    if (got !== SUM_A) begin
      testsFailed++;
      $display("[TB] FAIL basic_sum got %h expected %h", got, SUM_A);
    end
  endtask

  task automatic test_conj();
    logic [63:0] got;
    evq.delete();
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    conj_y = 1'b1;
    acc_len = 8'd1;
    strobes(1);
    conj_y = 1'b0;
    tick(10);
    got = (evq.size() > 0) ? evq[0].s : 64'hx;
    testsRun++;
    if (evq.size() !== 1) begin
      testsFailed++;
      $display("[TB] FAIL conj_count got %0d expected 1", evq.size());
    end
    testsRun++;
    if (got !== SUM_CONJ) begin
      testsFailed++;
      $display("[TB] FAIL conj_sum got %h expected %h", got, SUM_CONJ);
    end
  endtask

  task automatic test_accum();
    int c0;
    int lat0;
    int gap;
    logic [63:0] got0;
    logic [63:0] got1;
    evq.delete();
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    acc_len = 8'd4;
    c0 = cyc;
    strobes(8);
    tick(10);
    lat0 = (evq.size() > 0) ? evq[0].c - c0 : -1;
    gap  = (evq.size() > 1) ? evq[1].c - evq[0].c : -1;
    got0 = (evq.size() > 0) ? evq[0].s : 64'hx;
    got1 = (evq.size() > 1) ? evq[1].s : 64'hx;
    testsRun++;
    if (evq.size() !== 2) begin
      testsFailed++;
      $display("[TB] FAIL accum_count got %0d expected 2", evq.size());
    end
    testsRun++;
    if (lat0 !== 9) begin
      testsFailed++;
      $display("[TB] FAIL accum_first_latency got %0d expected 9", lat0);
    end
    testsRun++;
    if (gap !== 4) begin
      testsFailed++;
      $display("[TB] FAIL accum_spacing got %0d expected 4", gap);
    end
    testsRun++;
    if (got0 !== SUM_A4) begin
      testsFailed++;
      $display("[TB] FAIL accum_sum0 got %h expected %h", got0, SUM_A4);
    end
    testsRun++;
    if (got1 !== SUM_A4) begin
      testsFailed++;
      $display("[TB] FAIL accum_sum1 got %h expected %h", got1, SUM_A4);
    end
  endtask

  task automatic test_acclen_zero();
    int c0;
    int lat0;
    int lat1;
    logic [63:0] got1;
    evq.delete();
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    acc_len = 8'd0;
    c0 = cyc;
    strobes(2);
    tick(10);
    lat0 = (evq.size() > 0) ? evq[0].c - c0 : -1;
    lat1 = (evq.size() > 1) ? evq[1].c - c0 : -1;
    got1 = (evq.size() > 1) ? evq[1].s : 64'hx;
    testsRun++;
    if (evq.size() !== 2) begin
      testsFailed++;
      $display("[TB] FAIL len0_count got %0d expected 2", evq.size());
    end
    testsRun++;
    if (lat0 !== 6 || lat1 !== 7) begin
      testsFailed++;
      $display("[TB] FAIL len0_latency got %0d,%0d expected 6,7", lat0, lat1);
    end
    testsRun++;
    if (got1 !== SUM_A) begin
      testsFailed++;
      $display("[TB] FAIL len0_sum got %h expected %h", got1, SUM_A);
    end
  endtask

  task automatic test_stall();
    int c0;
    int lat;
    logic [63:0] got;
    evq.delete();
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    acc_len = 8'd1;
    c0 = cyc;
    strobes(1);
    tick(1);
    enable = 1'b0;
    input_strobe = 1'b1;
    tick(3);
    enable = 1'b1;
    input_strobe = 1'b0;
    tick(12);
    lat = (evq.size() > 0) ? evq[0].c - c0 : -1;
    got = (evq.size() > 0) ? evq[0].s : 64'hx;
    testsRun++;
    if (evq.size() !== 1) begin
      testsFailed++;
      $display("[TB] FAIL stall_count got %0d expected 1", evq.size());
    end
    testsRun++;
    if (lat !== 9) begin
      testsFailed++;
      $display("[TB] FAIL stall_latency got %0d expected 9", lat);
    end
    testsRun++;
    if (got !== SUM_A) begin
      testsFailed++;
      $display("[TB] FAIL stall_sum got %h expected %h", got, SUM_A);
    end
  endtask

  task automatic test_saturation();
    testsRun++;
    if (overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sat_pre_overflow got %b expected 0", overflow);
    end
    set_lanes(16'h8000, 16'd0, 16'h8000, 16'd0);
    acc_len = 8'd1;
    strobes(1);
    tick(10);
    testsRun++;
    if (sum !== SUM_SAT) begin
      testsFailed++;
      $display("[TB] FAIL sat_sum got %h expected %h", sum, SUM_SAT);
    end
    testsRun++;
    if (overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sat_overflow got %b expected 1", overflow);
    end
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    strobes(1);
    tick(10);
    testsRun++;
    if (sum !== SUM_A || overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sat_sticky got sum %h ovf %b expected %h ovf 1", sum, overflow, SUM_A);
    end
  endtask

  task automatic test_clear();
    logic [63:0] got;
    evq.delete();
    acc_len = 8'd4;
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    strobes(2);
    tick(8);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    set_lanes(16'd2, 16'd0, 16'd5, 16'd1);
    strobes(4);
    tick(12);
    got = (evq.size() > 0) ? evq[0].s : 64'hx;
    testsRun++;
    if (evq.size() !== 1) begin
      testsFailed++;
      $display("[TB] FAIL clear_count got %0d expected 1", evq.size());
    end
    testsRun++;
    if (got !== SUM_B4) begin
      testsFailed++;
      $display("[TB] FAIL clear_sum got %h expected %h", got, SUM_B4);
    end
  endtask

  task automatic test_reset_midblock();
    logic [63:0] got;
    set_lanes(16'h8000, 16'd0, 16'h8000, 16'd0);
    acc_len = 8'd1;
    strobes(1);
    tick(10);
    testsRun++;
    if (overflow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_pre_overflow got %b expected 1", overflow);
    end
    acc_len = 8'd4;
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    strobes(2);
    tick(8);
    evq.delete();
    reset = 1'b0;
    tick(1);
    testsRun++;
    if (sum !== 64'd0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_sum got %h expected 0", sum);
    end
    testsRun++;
    if (output_strobe !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_strobe got %b expected 0", output_strobe);
    end
    testsRun++;
    if (overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_overflow got %b expected 0", overflow);
    end
    reset = 1'b1;
    set_lanes(16'd2, 16'd0, 16'd5, 16'd1);
    strobes(4);
    tick(12);
    got = (evq.size() > 0) ? evq[0].s : 64'hx;
    testsRun++;
    if (evq.size() !== 1 || got !== SUM_B4) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_fresh got count %0d sum %h expected 1 and %h",
               evq.size(), got, SUM_B4);
    end
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b1;
    input_strobe = 1'b0;
    x_flat       = '0;
    y_flat       = '0;
    conj_y       = 1'b0;
    acc_len      = 8'd1;
    clear        = 1'b0;
    test_reset();
    test_basic();
    test_conj();
    test_accum();
    test_acclen_zero();
    test_stall();
    test_saturation();
    test_clear();
    test_reset_midblock();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
